// File: rtl/layer_scheduler.sv
// Convolution-layer sequencer: clears accumulators, issues one compute pass per input channel,
// then hands each output group to the ppu. Optional watchdog enabled by SCHED_WATCHDOG_EN.
module layer_scheduler #(
   parameter int unsigned BANK_COUNT      = 32,
   parameter int unsigned TILE_SIZE       = 128,
   parameter int unsigned CH_W            = 10,
   parameter int unsigned GRP_W           = 8,
   parameter int unsigned WATCHDOG_CYCLES = 65535,
   localparam int unsigned CLR_W          = $clog2(TILE_SIZE)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [CH_W-1:0]  num_in_channels,
   input  logic [GRP_W-1:0] num_out_groups,
   input  logic [1:0]       bitwidth,
   input  logic [2:0]       kernel_size,
   output logic [1:0]       cfg_bitwidth,
   output logic [2:0]       cfg_kernel_size,
   output logic             clear_enable,
   output logic [CLR_W-1:0] clear_entry,
   output logic             compute_start,
   output logic [CH_W-1:0]  compute_channel,
   input  logic             compute_done,
   output logic             channel_group_done,
   input  logic             ppu_cycle_done,
   output logic [GRP_W-1:0] group_index,
   output logic             busy,
   output logic             done,
   output logic             timeout
);

   localparam logic [2:0] S_IDLE         = 3'd0;
   localparam logic [2:0] S_CLEAR        = 3'd1;
   localparam logic [2:0] S_ISSUE        = 3'd2;
   localparam logic [2:0] S_WAIT_COMPUTE = 3'd3;
   localparam logic [2:0] S_DRAIN        = 3'd4;
   localparam logic [2:0] S_WAIT_PPU     = 3'd5;
   localparam logic [2:0] S_FINISH       = 3'd6;

   // Every bank is cleared in parallel, so the bank count only needs to be legal here.
   if (BANK_COUNT == 0 || TILE_SIZE < 2 || WATCHDOG_CYCLES == 0) begin : g_bad_params
      $error("layer_scheduler: illegal parameter value");
   end

   logic [2:0]       r_state;
   logic [CLR_W-1:0] r_clr;
   logic [CH_W-1:0]  r_chan;
   logic [GRP_W-1:0] r_grp;
   logic [CH_W-1:0]  r_num_in;
   logic [GRP_W-1:0] r_num_grp;

   logic [2:0]       w_state_nxt;
   logic [CLR_W-1:0] w_clr_nxt;
   logic [CH_W-1:0]  w_chan_nxt;
   logic [GRP_W-1:0] w_grp_nxt;
   logic             w_latch;
   logic             w_wd_fire;

`ifdef SCHED_WATCHDOG_EN
   localparam int unsigned WD_W = $clog2(WATCHDOG_CYCLES + 1);
   logic [WD_W-1:0] r_wd;
   logic            w_wd_last;

   assign w_wd_last = (r_wd == WD_W'(WATCHDOG_CYCLES - 1));
`else
   logic w_wd_last;

   assign w_wd_last = 1'b0;
`endif

   // Next-state and counter update logic.
   always_comb begin
      w_state_nxt = r_state;
      w_clr_nxt   = r_clr;
      w_chan_nxt  = r_chan;
      w_grp_nxt   = r_grp;
      w_latch     = 1'b0;
      w_wd_fire   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_latch    = 1'b1;
               w_clr_nxt  = '0;
               w_chan_nxt = '0;
               w_grp_nxt  = '0;
               if (num_in_channels == '0 || num_out_groups == '0) w_state_nxt = S_FINISH;
               else                                               w_state_nxt = S_CLEAR;
            end
         end
         S_CLEAR: begin
            if (r_clr == CLR_W'(TILE_SIZE - 1)) begin
               w_clr_nxt   = '0;
               w_state_nxt = S_ISSUE;
            end else begin
               w_clr_nxt = r_clr + CLR_W'(1);
            end
         end
         S_ISSUE: w_state_nxt = S_WAIT_COMPUTE;
         S_WAIT_COMPUTE: begin
            if (compute_done) begin
               if (r_chan == r_num_in - CH_W'(1)) begin
                  w_chan_nxt  = '0;
                  w_state_nxt = S_DRAIN;
               end else begin
                  w_chan_nxt  = r_chan + CH_W'(1);
                  w_state_nxt = S_ISSUE;
               end
            end else if (w_wd_last) begin
               w_wd_fire   = 1'b1;
               w_state_nxt = S_IDLE;
            end
         end
         S_DRAIN: w_state_nxt = S_WAIT_PPU;
         S_WAIT_PPU: begin
            if (ppu_cycle_done) begin
               if (r_grp == r_num_grp - GRP_W'(1)) begin
                  w_state_nxt = S_FINISH;
               end else begin
                  w_grp_nxt   = r_grp + GRP_W'(1);
                  w_state_nxt = S_CLEAR;
               end
            end else if (w_wd_last) begin
               w_wd_fire   = 1'b1;
               w_state_nxt = S_IDLE;
            end
         end
         S_FINISH: w_state_nxt = S_IDLE;
         default:  w_state_nxt = S_IDLE;
      endcase
   end

   // State, counters and latched layer configuration.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state         <= S_IDLE;
         r_clr           <= '0;
         r_chan          <= '0;
         r_grp           <= '0;
         r_num_in        <= '0;
         r_num_grp       <= '0;
         cfg_bitwidth    <= '0;
         cfg_kernel_size <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_clr   <= w_clr_nxt;
         r_chan  <= w_chan_nxt;
         r_grp   <= w_grp_nxt;
         if (w_latch) begin
            r_num_in        <= num_in_channels;
            r_num_grp       <= num_out_groups;
            cfg_bitwidth    <= bitwidth;
            cfg_kernel_size <= kernel_size;
         end
      end
   end

   // Registered output decode of the current state.
   always_ff @(posedge clk) begin
      if (reset) begin
         clear_enable       <= 1'b0;
         clear_entry        <= '0;
         compute_start      <= 1'b0;
         compute_channel    <= '0;
         channel_group_done <= 1'b0;
         group_index        <= '0;
         busy               <= 1'b0;
         done               <= 1'b0;
      end else begin
         clear_enable       <= (r_state == S_CLEAR);
         clear_entry        <= r_clr;
         compute_start      <= (r_state == S_ISSUE);
         compute_channel    <= r_chan;
         channel_group_done <= (r_state == S_DRAIN);
         group_index        <= r_grp;
         busy               <= (r_state != S_IDLE);
         done               <= (r_state == S_FINISH);
      end
   end

`ifdef SCHED_WATCHDOG_EN
   // Wait-state watchdog; restarts whenever a wait state is entered.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_wd    <= '0;
         timeout <= 1'b0;
      end else begin
         if (r_state == S_ISSUE || r_state == S_DRAIN) r_wd <= '0;
         else if (r_state == S_WAIT_COMPUTE || r_state == S_WAIT_PPU) r_wd <= r_wd + WD_W'(1);
         if (w_wd_fire) timeout <= 1'b1;
      end
   end
`else
   logic w_unused_wd;

   assign w_unused_wd = w_wd_fire;
   assign timeout     = 1'b0;
`endif

endmodule

// File: tb/tb_layer_scheduler.sv
// Scoreboard bench for layer_scheduler; watchdog checks follow SCHED_WATCHDOG_EN.
module tb_layer_scheduler;

   localparam int unsigned CH_W  = 10;
   localparam int unsigned GRP_W = 8;
   localparam int unsigned TILE  = 128;
   localparam int unsigned CLR_W = 7;
`ifdef SCHED_WATCHDOG_EN
   localparam int unsigned WD = 20;
`else
   localparam int unsigned WD = 65535;
`endif

   logic             clk = 1'b0;
   logic             reset;
   logic             start;
   logic [CH_W-1:0]  num_in_channels;
   logic [GRP_W-1:0] num_out_groups;
   logic [1:0]       bitwidth;
   logic [2:0]       kernel_size;
   logic [1:0]       cfg_bitwidth;
   logic [2:0]       cfg_kernel_size;
   logic             clear_enable;
   logic [CLR_W-1:0] clear_entry;
   logic             compute_start;
   logic [CH_W-1:0]  compute_channel;
   logic             compute_done;
   logic             channel_group_done;
   logic             ppu_cycle_done;
   logic [GRP_W-1:0] group_index;
   logic             busy;
   logic             done;
   logic             timeout;

   int n_cmp = 0;
   int n_err = 0;
   int exp_chan_q[$];
   int exp_cgrp_q[$];
   int exp_grp_q[$];

   always #5 clk = ~clk;

   layer_scheduler #(
      .BANK_COUNT(32), .TILE_SIZE(TILE), .CH_W(CH_W), .GRP_W(GRP_W), .WATCHDOG_CYCLES(WD)
   ) dut (
      .clk(clk), .reset(reset), .start(start),
      .num_in_channels(num_in_channels), .num_out_groups(num_out_groups),
      .bitwidth(bitwidth), .kernel_size(kernel_size),
      .cfg_bitwidth(cfg_bitwidth), .cfg_kernel_size(cfg_kernel_size),
      .clear_enable(clear_enable), .clear_entry(clear_entry),
      .compute_start(compute_start), .compute_channel(compute_channel),
      .compute_done(compute_done), .channel_group_done(channel_group_done),
      .ppu_cycle_done(ppu_cycle_done), .group_index(group_index),
      .busy(busy), .done(done), .timeout(timeout)
   );

   task automatic step();
      @(negedge clk);
   endtask

   function automatic logic [35:0] all_outs();
      return {cfg_bitwidth, cfg_kernel_size, clear_enable, clear_entry, compute_start,
              compute_channel, channel_group_done, group_index, busy, done, timeout};
   endfunction

   // Runs one layer with a modelled fusion array and ppu; checks pulses against the scoreboard.
   task automatic run_layer(input int nin, input int ngr, input int bw, input int ks,
                            input int cdly, input int pdly, input bit hold_cd,
                            input bit stray, input bit restart,
                            output int n_cs, output int n_cgd, output int n_done, output int n_clr);
      int cd_cnt, pd_cnt, clr_exp, tail, n_cfg_bad, n_clr_bad, e_c, e_g;
      bit stray_done, restart_done, cd_p, ppu_p;
      n_cs = 0; n_cgd = 0; n_done = 0; n_clr = 0; n_cfg_bad = 0; n_clr_bad = 0;
      cd_cnt = -1; pd_cnt = -1; clr_exp = 0; tail = -1;
      stray_done = 1'b0; restart_done = 1'b0;
      exp_chan_q.delete(); exp_cgrp_q.delete(); exp_grp_q.delete();
      if (nin > 0) begin
         for (int g = 0; g < ngr; g++) begin
            exp_grp_q.push_back(g);
            for (int c = 0; c < nin; c++) begin
               exp_chan_q.push_back(c);
               exp_cgrp_q.push_back(g);
            end
         end
      end
      num_in_channels = CH_W'(nin);
      num_out_groups  = GRP_W'(ngr);
      bitwidth        = 2'(bw);
      kernel_size     = 3'(ks);
      start           = 1'b1;
      step();
      start           = 1'b0;
      num_in_channels = CH_W'(nin + 5);
      num_out_groups  = '1;
      bitwidth        = 2'(bw + 1);
      kernel_size     = 3'(ks + 2);
      for (int cyc = 0; cyc < 20000 && tail != 0; cyc++) begin
         if (cfg_bitwidth !== 2'(bw) || cfg_kernel_size !== 3'(ks)) n_cfg_bad++;
         if (clear_enable) begin
            n_clr++;
            if (clear_entry !== CLR_W'(clr_exp)) n_clr_bad++;
            clr_exp = (clr_exp + 1) % TILE;
         end
         if (compute_start) begin
            n_cs++;
            cd_cnt = cdly;
            n_cmp++;
            if (exp_chan_q.size() == 0) begin
               n_err++;
               $display("FAIL compute_start: unexpected pulse, channel=%0d", compute_channel);
            end else begin
               e_c = exp_chan_q.pop_front();
               e_g = exp_cgrp_q.pop_front();
               if (compute_channel !== CH_W'(e_c) || group_index !== GRP_W'(e_g)) begin
                  n_err++;
                  $display("FAIL compute_start: channel/group %0d/%0d, required %0d/%0d",
                           compute_channel, group_index, e_c, e_g);
               end
            end
         end
         if (channel_group_done) begin
            n_cgd++;
            pd_cnt = pdly;
            n_cmp++;
            if (exp_grp_q.size() == 0) begin
               n_err++;
               $display("FAIL channel_group_done: unexpected pulse, group=%0d", group_index);
            end else begin
               e_g = exp_grp_q.pop_front();
               if (group_index !== GRP_W'(e_g)) begin
                  n_err++;
                  $display("FAIL channel_group_done: group %0d, required %0d", group_index, e_g);
               end
            end
         end
         if (done) begin
            n_done++;
            if (tail < 0) tail = 12;
         end
         if (tail > 0) tail--;
         cd_p = hold_cd || (cd_cnt == 0);
         if (cd_cnt >= 0) cd_cnt--;
         ppu_p = (pd_cnt == 0);
         if (pd_cnt >= 0) pd_cnt--;
         if (stray && !stray_done && clear_enable && clear_entry == CLR_W'(50)) begin
            ppu_p      = 1'b1;
            stray_done = 1'b1;
         end
         compute_done   = cd_p;
         ppu_cycle_done = ppu_p;
         if (restart && !restart_done && n_cs == 2) begin
            start           = 1'b1;
            num_in_channels = CH_W'(1);
            num_out_groups  = GRP_W'(1);
            bitwidth        = 2'(bw ^ 1);
            kernel_size     = 3'(ks ^ 2);
            restart_done    = 1'b1;
         end else begin
            start = 1'b0;
         end
         step();
      end
      compute_done = 1'b0; ppu_cycle_done = 1'b0; start = 1'b0;
      n_cmp++;
      if (tail != 0) begin
         n_err++;
         $display("FAIL layer_complete: done not seen within budget, in=%0d groups=%0d", nin, ngr);
      end
      n_cmp++;
      if (exp_chan_q.size() != 0 || exp_grp_q.size() != 0) begin
         n_err++;
         $display("FAIL scoreboard_drained: %0d passes and %0d drains left, required 0/0",
                  exp_chan_q.size(), exp_grp_q.size());
      end
      n_cmp++;
      if (n_clr_bad != 0) begin
         n_err++;
         $display("FAIL clear_entry_sequence: %0d out-of-order entries, required 0", n_clr_bad);
      end
      n_cmp++;
      if (n_cfg_bad != 0) begin
         n_err++;
         $display("FAIL cfg_hold: %0d cycles with wrong cfg, required 0", n_cfg_bad);
      end
      n_cmp++;
      if (busy !== 1'b0) begin
         n_err++;
         $display("FAIL busy_after_layer: busy=%b, required 0", busy);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 1'b0; compute_done = 1'b0; ppu_cycle_done = 1'b0;
      num_in_channels = '0; num_out_groups = '0; bitwidth = '0; kernel_size = '0;
      repeat (3) step();
      reset = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step();
         n_cmp++;
         if (all_outs() !== 36'd0) begin
            n_err++;
            $display("FAIL reset_idle: outputs=%h, required 0", all_outs());
         end
      end
   endtask

   task automatic test_basic();
      int cs, cgd, dn, clr;
      run_layer(3, 2, 2, 3, 4, 10, 1'b0, 1'b0, 1'b0, cs, cgd, dn, clr);
      n_cmp++;
      if (cs != 6 || cgd != 2 || dn != 1 || clr != 2 * TILE) begin
         n_err++;
         $display("FAIL basic_counts: cs/cgd/done/clear %0d/%0d/%0d/%0d, required 6/2/1/%0d",
                  cs, cgd, dn, clr, 2 * TILE);
      end
   endtask

   task automatic test_zero_count();
      int stray_pulses, cs, cgd, dn, clr;
      stray_pulses = 0;
      num_in_channels = '0; num_out_groups = GRP_W'(4); bitwidth = 2'd1; kernel_size = 3'd5;
      start = 1'b1;
      step();
      start = 1'b0;
      stray_pulses += int'(clear_enable) + int'(compute_start) + int'(channel_group_done);
      n_cmp++;
      if (done !== 1'b0) begin
         n_err++;
         $display("FAIL zero_in_done_early: done=%b one cycle after start, required 0", done);
      end
      step();
      stray_pulses += int'(clear_enable) + int'(compute_start) + int'(channel_group_done);
      n_cmp++;
      if (done !== 1'b1) begin
         n_err++;
         $display("FAIL zero_in_done: done=%b two cycles after start, required 1", done);
      end
      for (int i = 0; i < 6; i++) begin
         step();
         stray_pulses += int'(clear_enable) + int'(compute_start) + int'(channel_group_done) + int'(done);
      end
      n_cmp++;
      if (stray_pulses != 0 || busy !== 1'b0) begin
         n_err++;
         $display("FAIL zero_in_quiet: %0d stray pulses busy=%b, required 0/0", stray_pulses, busy);
      end
      run_layer(3, 0, 3, 1, 2, 2, 1'b0, 1'b0, 1'b0, cs, cgd, dn, clr);
      n_cmp++;
      if (cs != 0 || cgd != 0 || dn != 1 || clr != 0) begin
         n_err++;
         $display("FAIL zero_groups: cs/cgd/done/clear %0d/%0d/%0d/%0d, required 0/0/1/0",
                  cs, cgd, dn, clr);
      end
   endtask

   task automatic test_held_done();
      int cs, cgd, dn, clr;
      run_layer(2, 2, 1, 5, 0, 3, 1'b1, 1'b1, 1'b0, cs, cgd, dn, clr);
      n_cmp++;
      if (cs != 4 || cgd != 2 || dn != 1 || clr != 2 * TILE) begin
         n_err++;
         $display("FAIL held_done_counts: cs/cgd/done/clear %0d/%0d/%0d/%0d, required 4/2/1/%0d",
                  cs, cgd, dn, clr, 2 * TILE);
      end
   endtask

   task automatic test_restart_ignored();
      int cs, cgd, dn, clr;
      run_layer(3, 1, 3, 7, 2, 2, 1'b0, 1'b0, 1'b1, cs, cgd, dn, clr);
      n_cmp++;
      if (cs != 3 || cgd != 1 || dn != 1) begin
         n_err++;
         $display("FAIL restart_counts: cs/cgd/done %0d/%0d/%0d, required 3/1/1", cs, cgd, dn);
      end
   endtask

   task automatic test_reset_mid();
      bit found;
      int pulses;
      found = 1'b0; pulses = 0;
      num_in_channels = CH_W'(3); num_out_groups = GRP_W'(1); bitwidth = 2'd1; kernel_size = 3'd3;
      start = 1'b1;
      step();
      start = 1'b0;
      for (int i = 0; i < 300 && !found; i++) begin
         if (compute_start) found = 1'b1;
         else step();
      end
      n_cmp++;
      if (!found) begin
         n_err++;
         $display("FAIL reset_mid_issue: no compute_start seen, required one");
      end
      step(); step();
      reset = 1'b1;
      step();
      n_cmp++;
      if (all_outs() !== 36'd0) begin
         n_err++;
         $display("FAIL reset_mid_outputs: outputs=%h busy=%b, required 0", all_outs(), busy);
      end
      step();
      reset = 1'b0;
      for (int i = 0; i < 20; i++) begin
         step();
         pulses += int'(compute_start) + int'(channel_group_done) + int'(done) + int'(busy);
      end
      n_cmp++;
      if (pulses != 0) begin
         n_err++;
         $display("FAIL reset_mid_quiet: %0d pulses after reset, required 0", pulses);
      end
   endtask

   task automatic test_watchdog();
      bit found;
      found = 1'b0;
      num_in_channels = CH_W'(2); num_out_groups = GRP_W'(1); bitwidth = 2'd2; kernel_size = 3'd1;
      start = 1'b1;
      step();
      start = 1'b0;
      for (int i = 0; i < 300 && !found; i++) begin
         if (compute_start) found = 1'b1;
         else step();
      end
      n_cmp++;
      if (!found) begin
         n_err++;
         $display("FAIL watchdog_issue: no compute_start seen, required one");
      end
`ifdef SCHED_WATCHDOG_EN
      begin
         int tmo_at, cs, cgd, dn, clr;
         bit saw_done;
         tmo_at = -1; saw_done = 1'b0;
         for (int i = 1; i <= 40 && tmo_at < 0; i++) begin
            step();
            if (done) saw_done = 1'b1;
            if (timeout === 1'b1) tmo_at = i;
         end
         n_cmp++;
         if (tmo_at != int'(WD)) begin
            n_err++;
            $display("FAIL watchdog_latency: timeout after %0d cycles, required %0d", tmo_at, WD);
         end
         for (int i = 0; i < 5; i++) begin
            step();
            if (done) saw_done = 1'b1;
         end
         n_cmp++;
         if (busy !== 1'b0 || saw_done) begin
            n_err++;
            $display("FAIL watchdog_abort: busy=%b done_seen=%b, required 0/0", busy, saw_done);
         end
         run_layer(1, 1, 2, 1, 1, 1, 1'b0, 1'b0, 1'b0, cs, cgd, dn, clr);
         n_cmp++;
         if (dn != 1 || timeout !== 1'b1) begin
            n_err++;
            $display("FAIL watchdog_restart: done=%0d timeout=%b, required 1/1", dn, timeout);
         end
      end
`else
      begin
         int extra;
         extra = 0;
         for (int i = 0; i < 1000; i++) begin
            step();
            extra += int'(compute_start) + int'(channel_group_done) + int'(done);
         end
         n_cmp++;
         if (busy !== 1'b1 || timeout !== 1'b0 || extra != 0 || compute_channel !== CH_W'(0)) begin
            n_err++;
            $display("FAIL wait_blocks: busy=%b timeout=%b pulses=%0d ch=%0d, required 1/0/0/0",
                     busy, timeout, extra, compute_channel);
         end
         reset = 1'b1;
         step();
         reset = 1'b0;
         step();
      end
`endif
   endtask

   initial begin
      test_reset();
      test_basic();
      test_zero_count();
      test_held_done();
      test_restart_ignored();
      test_reset_mid();
      test_watchdog();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not finish within the time limit");
      $fatal(1, "tb_layer_scheduler: time limit exceeded");
   end

endmodule

// File: doc/layer_scheduler.md
Name: layer_scheduler

Overview:
- Top-level sequencer for one convolution layer on a bitfuscnn tile.
- Walks output channel groups. For each group it:
  - clears the accumulator buffer entries,
  - issues one compute pass per input channel to the fusion-unit array,
  - hands the filled accumulators to the ppu through a drain handshake.
- Latches layer configuration (bitwidth, kernel size) on start and holds it stable for the datapath.

Parameters:
- BANK_COUNT, 32, accumulator banks; all banks are cleared in parallel.
- TILE_SIZE, 128, entries per bank to clear; clear_entry width is $clog2(TILE_SIZE).
- CH_W, 10, width of input-channel count and index.
- GRP_W, 8, width of output-group count and index.
- WATCHDOG_CYCLES, 65535, timeout limit; used only with SCHED_WATCHDOG_EN.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle launch request; sampled only in IDLE.
- num_in_channels  in  CH_W  input channels per group; latched on start.
- num_out_groups  in  GRP_W  output channel groups; latched on start.
- bitwidth  in  2  layer bitwidth; latched on start.
- kernel_size  in  3  layer kernel size; latched on start.
- cfg_bitwidth  out  2  latched bitwidth.
- cfg_kernel_size  out  3  latched kernel size.
- clear_enable  out  1  high while accumulator entries are being zeroed.
- clear_entry  out  $clog2(TILE_SIZE)  entry being zeroed in every bank.
- compute_start  out  1  one-cycle pulse that launches a compute pass.
- compute_channel  out  CH_W  input channel for the current pass.
- compute_done  in  1  fusion array pass complete.
- channel_group_done  out  1  one-cycle pulse telling the ppu to drain.
- ppu_cycle_done  in  1  ppu drain and neighbor exchange complete.
- group_index  out  GRP_W  current output group.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at layer completion.
- timeout  out  1  sticky watchdog flag.

Behaviour:
- Reset: state=IDLE. All outputs 0; counters and latched config 0. Reset mid-operation aborts immediately, with no further pulses.
- States: IDLE, CLEAR, ISSUE, WAIT_COMPUTE, DRAIN, WAIT_PPU, FINISH.
- IDLE:
  - On start=1, latch all config inputs and zero both counters.
  - If num_in_channels==0 or num_out_groups==0, go to FINISH; otherwise go to CLEAR.
  - start outside IDLE is ignored.
- CLEAR:
  - clear_enable=1 with clear_entry = 0,1,...,TILE_SIZE-1 on consecutive cycles (TILE_SIZE cycles total).
  - After entry TILE_SIZE-1, go to ISSUE.
- ISSUE: compute_start=1 for exactly one cycle with compute_channel = channel counter; go to WAIT_COMPUTE.
- WAIT_COMPUTE:
  - compute_done is sampled only in this state; it is ignored elsewhere, including the ISSUE cycle.
  - On compute_done with channel == num_in_channels-1, reset the channel counter to 0 and go to DRAIN.
  - Otherwise increment the channel counter and go to ISSUE.
- DRAIN: channel_group_done=1 for one cycle; go to WAIT_PPU.
- WAIT_PPU:
  - ppu_cycle_done is sampled only in this state.
  - On ppu_cycle_done with group == num_out_groups-1, go to FINISH.
  - Otherwise increment the group counter and go to CLEAR.
- FINISH: done=1 for one cycle; go to IDLE. Latched config is retained in IDLE.
- Outputs are registered.
  - compute_channel and group_index reflect the counters in every state.
  - Counters never exceed count-1 and never wrap; the full-width maximum count is legal.
- Per-group latency: TILE_SIZE + 2·num_in_channels + 2 cycles, plus the datapath wait cycles.
- A done input (compute_done or ppu_cycle_done) held high for several cycles advances only once per visit to its wait state.

Optional Feature:
- Macro: SCHED_WATCHDOG_EN.
- Defined:
  - A counter runs in WAIT_COMPUTE and WAIT_PPU and resets on entering either state.
  - When the count reaches WATCHDOG_CYCLES with no done input, the scheduler sets timeout=1 (sticky until reset) and returns to IDLE without pulsing done.
  - The next start still works and does not clear timeout.
- Not defined: there is no counter, the wait states block indefinitely, and timeout is tied 0.

Test Plan:
- Reset, then idle 5 cycles -> all outputs 0. Assert reset during WAIT_COMPUTE -> next cycle busy=0, with no compute_start, channel_group_done or done pulses.
- start with in=3, groups=2, bitwidth=2, kernel=3; compute_done 4 cycles after each compute_start; ppu_cycle_done 10 cycles after channel_group_done:
  - 128 clear cycles per group;
  - compute_channel sequence 0,1,2;
  - exactly 6 compute_start and 2 channel_group_done pulses;
  - group_index 0 then 1;
  - cfg_bitwidth=2 and cfg_kernel_size=3 throughout;
  - done once.
- start with num_in_channels=0 -> done two cycles after start; no clear, compute_start or channel_group_done.
- compute_done held high continuously plus a stray ppu_cycle_done during CLEAR -> each channel advances once per ISSUE; the stray pulse is ignored.
- start pulsed again mid-layer with different config -> ignored; latched values unchanged.
- SCHED_WATCHDOG_EN with WATCHDOG_CYCLES=20 and compute_done withheld -> timeout=1 after 20 cycles in WAIT_COMPUTE, IDLE, no done. Without the macro -> the scheduler is still in WAIT_COMPUTE after 1000 cycles with timeout=0.
